// File: rtl/bist_ctrl.sv
// bist_ctrl: sequences one BIST session: clear the pattern generator and
// signature registers, apply N_PAT patterns, wait CMP_LAT cycles for the
// comparator, then latch pass/fail and pulse done.
// Optional build macro BIST_CTRL_STICKY_ERR_EN: keep a sticky error flag over
// RUN/WAIT/EVAL so that any mismatch seen during the session fails it.
module bist_ctrl #(
  parameter int N_PAT   = 7,  // 1..15
  parameter int CMP_LAT = 1   // 0..3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       e,
  output logic       enable,
  output logic       tpg_clr,
  output logic [3:0] pat_cnt,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, WAIT, EVAL, DONE} state_t;

  localparam logic [3:0] PAT_LAST  = 4'(N_PAT - 1);
  localparam logic [1:0] WAIT_LAST = 2'((CMP_LAT > 0) ? CMP_LAT - 1 : 0);

  state_t     state_q, state_d;
  logic [3:0] pat_q, pat_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;
  logic       eval_err;

`ifdef BIST_CTRL_STICKY_ERR_EN
  logic err_q, err_d;

  // Sticky mismatch flag: set while testing, cleared by CLEAR or reset
  always_comb begin
    err_d = err_q;
    if (state_q == CLEAR) err_d = 1'b0;
    else if (e && (state_q inside {RUN, WAIT, EVAL})) err_d = 1'b1;
  end

  // Error flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign eval_err = err_q | e;
`else
  assign eval_err = e;
`endif

  // Next-state, pattern index, wait counter and verdict logic
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    wcnt_d  = wcnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = CLEAR;
        pat_d   = 4'd0;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
      end
      CLEAR: begin
        state_d = RUN;
        pat_d   = 4'd0;
      end
      RUN: begin
        if (pat_q == PAT_LAST) begin
          // pat_cnt parks on the last index through WAIT/EVAL
          state_d = (CMP_LAT > 0) ? WAIT : EVAL;
          wcnt_d  = 2'd0;
        end else begin
          pat_d = pat_q + 4'd1;
        end
      end
      WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = EVAL;
        else                     wcnt_d  = wcnt_q + 2'd1;
      end
      EVAL: begin
        state_d = DONE;
        fail_d  = eval_err;
        pass_d  = ~eval_err;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over everything once a session is in progress
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      pat_d   = 4'd0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pat_q   <= 4'd0;
      wcnt_q  <= 2'd0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      wcnt_q  <= wcnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // Output decode straight from state so reset clears outputs immediately
  always_comb begin
    enable  = state_q inside {RUN, WAIT, EVAL};
    tpg_clr = (state_q == CLEAR);
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    pat_cnt = pat_q;
    pass    = pass_q;
    fail    = fail_q;
  end

endmodule

// File: doc/bist_ctrl.md
BIST_CTRL -- requirements
Module: bist_ctrl

Interface
REQ-001 The module SHALL have parameter N_PAT, default 7, giving patterns applied per test session; legal range 1..15.
REQ-002 The module SHALL have parameter CMP_LAT, default 1, giving cycles from the last pattern to a valid comparator flag; legal range 0..3.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  session request, sampled only in IDLE.
REQ-006 abort  input  1  terminates a running session.
REQ-007 e  input  1  comparator mismatch flag, 1 = signature mismatch.
REQ-008 enable  output  1  test-mode select to pattern generator, muxes, signature registers and comparator.
REQ-009 tpg_clr  output  1  one-cycle clear to pattern generator and signature registers.
REQ-010 pat_cnt  output  4  index of the pattern currently applied.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle session-complete pulse.
REQ-013 pass  output  1  last session matched; held until the next CLEAR.
REQ-014 fail  output  1  last session mismatched; held until the next CLEAR.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, CLEAR, RUN, WAIT, EVAL and DONE.
REQ-016 In IDLE, enable SHALL be 0, and start=1 SHALL move the FSM to CLEAR.
REQ-017 CLEAR SHALL last one cycle with tpg_clr=1, enable=0, pat_cnt=0, pass=0 and fail=0, then move to RUN.
REQ-018 In RUN, enable SHALL be 1 and pat_cnt SHALL increment each cycle from 0.
REQ-019 When pat_cnt=N_PAT-1 in RUN, the FSM SHALL go to WAIT if CMP_LAT>0 and to EVAL otherwise; pat_cnt SHALL then hold at N_PAT-1.
REQ-020 WAIT SHALL last exactly CMP_LAT cycles with enable=1.
REQ-021 EVAL SHALL last one cycle with enable=1; it SHALL register fail=e and pass=~e, then move to DONE.
REQ-022 DONE SHALL last one cycle with done=1 and enable=0, then move to IDLE.
REQ-023 With start sampled at edge 0, done SHALL be high in cycle N_PAT+CMP_LAT+3 (cycle 11 with default parameters), with pass/fail valid in the same cycle.
REQ-024 start SHALL be ignored outside IDLE; if start is held high, a new session SHALL begin on the first IDLE cycle.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with enable=0, pass=0, fail=0 and no done pulse.
REQ-026 If abort and start are both 1 in IDLE, the FSM SHALL stay in IDLE.
REQ-027 pass and fail SHALL never both be 1; tpg_clr and enable SHALL never both be 1.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, with enable, tpg_clr, pat_cnt, busy, done, pass and fail all 0 and the internal error flag cleared.
REQ-029 Asserting reset mid-session SHALL abandon the session without a done pulse; operation SHALL resume on the first clk edge after reset=1.

Configuration
REQ-030 When macro BIST_CTRL_STICKY_ERR_EN is defined, an internal error flag SHALL set on any cycle in RUN, WAIT or EVAL with e=1, and EVAL SHALL report fail=(flag|e).
REQ-031 The error flag SHALL clear only in CLEAR or on reset.
REQ-032 When BIST_CTRL_STICKY_ERR_EN is undefined, e SHALL be sampled only in EVAL, and no error flag SHALL exist.

Verification
REQ-033 Defaults; pulse start at cycle 0 with e=0 throughout -> tpg_clr=1 in cycle 1, enable=1 in cycles 2-10, pat_cnt 0..6, done=1 in cycle 11, pass=1, fail=0.
REQ-034 Defaults; e=1 only in the EVAL cycle (cycle 10) -> done in cycle 11 with fail=1, pass=0.
REQ-035 Defaults; e=1 only in cycle 4 -> with macro defined fail=1 in cycle 11; without it pass=1.
REQ-036 Defaults; abort=1 in cycle 5 -> cycle 6 shows IDLE, enable=0, busy=0, and done stays 0 through cycle 20.
REQ-037 Defaults; reset=0 asynchronously mid-cycle 7 -> all outputs 0 before the next edge; after release, start begins a full session with done 11 cycles after start.
REQ-038 N_PAT=1, CMP_LAT=0, start held high -> sessions run back-to-back with done at cycle 4, then every 5 cycles.
